// File: rtl/gray_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_counter_if : control/status bundle of the Gray-code counter      |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface gray_counter_if #(
   parameter int WIDTH = 4
);
   logic             En;
   logic             Dir;
   logic             Load;
   logic [WIDTH-1:0] LoadVal;
   logic             ClrFlag;
   logic [WIDTH-1:0] Output;
   logic [WIDTH-1:0] Binary;
   logic             Overflow;
   logic             Underflow;
   logic             Wrap;

   modport master (
      output En, Dir, Load, LoadVal, ClrFlag,
      input  Output, Binary, Overflow, Underflow, Wrap
   );

   modport slave (
      input  En, Dir, Load, LoadVal, ClrFlag,
      output Output, Binary, Overflow, Underflow, Wrap
   );
endinterface
`default_nettype wire

// File: rtl/gray_counter_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_counter_n : up/down binary counter with registered Gray output, |
// | wrap/saturate modes and sticky overflow/underflow flags.             |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module gray_counter_n #(
   parameter int WIDTH    = 4,
   parameter bit SATURATE = 1'b0
) (
   input  wire logic       Clk,
   input  wire logic       Reset,
   gray_counter_if.slave   bus
);
   localparam logic [WIDTH-1:0] C_MAX  = '1;
   localparam logic [WIDTH-1:0] C_ZERO = '0;
   localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_bin   = '0;
   logic [WIDTH-1:0] r_gray  = '0;
   logic             r_ovf   = 1'b0;
   logic             r_unf   = 1'b0;
   logic             r_wrap  = 1'b0;

   logic [WIDTH-1:0] w_load_bin;
   logic [WIDTH-1:0] w_bin_nxt;
   logic             w_ovf_nxt;
   logic             w_unf_nxt;
   logic             w_wrap_nxt;

   // Binary bit i is the XOR of all Gray bits from i upward.
   always_comb begin
      w_load_bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_load_bin[i] = ^(bus.LoadVal >> i);
      end
   end

   always_comb begin
      w_bin_nxt  = r_bin;
      w_ovf_nxt  = r_ovf & ~bus.ClrFlag;
      w_unf_nxt  = r_unf & ~bus.ClrFlag;
      w_wrap_nxt = 1'b0;
      if (bus.Load) begin
         w_bin_nxt = w_load_bin;
      end else if (bus.En) begin
         if (!bus.Dir) begin
            if (r_bin == C_MAX) begin
               w_ovf_nxt = 1'b1;
               if (!SATURATE) begin
                  w_bin_nxt  = C_ZERO;
                  w_wrap_nxt = 1'b1;
               end
            end else begin
               w_bin_nxt = r_bin + C_ONE;
            end
         end else begin
            if (r_bin == C_ZERO) begin
               w_unf_nxt = 1'b1;
               if (!SATURATE) begin
                  w_bin_nxt  = C_MAX;
                  w_wrap_nxt = 1'b1;
               end
            end else begin
               w_bin_nxt = r_bin - C_ONE;
            end
         end
      end
   end

   // Gray is re-encoded from the next binary value so both outputs update together.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_bin  <= '0;
         r_gray <= '0;
         r_ovf  <= 1'b0;
         r_unf  <= 1'b0;
         r_wrap <= 1'b0;
      end else begin
         r_bin  <= w_bin_nxt;
         r_gray <= w_bin_nxt ^ (w_bin_nxt >> 1);
         r_ovf  <= w_ovf_nxt;
         r_unf  <= w_unf_nxt;
         r_wrap <= w_wrap_nxt;
      end
   end

   assign bus.Output    = r_gray;
   assign bus.Binary    = r_bin;
   assign bus.Overflow  = r_ovf;
   assign bus.Underflow = r_unf;
   assign bus.Wrap      = r_wrap;
endmodule
`default_nettype wire

// File: tb/tb_gray_counter_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gray_counter_n : directed vectors for wrap, saturate and 8-bit     |
// | sweep configurations of gray_counter_n.  Revision 1.0                 |
// +----------------------------------------------------------------------+
module tb_gray_counter_n;
   logic Clk = 1'b0;
   logic rst_a = 1'b0;
   logic rst_s = 1'b0;
   logic rst_w = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 Clk = ~Clk;

   gray_counter_if #(.WIDTH(3)) if_a ();
   gray_counter_if #(.WIDTH(3)) if_s ();
   gray_counter_if #(.WIDTH(8)) if_w ();

   gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) dut_a (.Clk(Clk), .Reset(rst_a), .bus(if_a.slave));
   gray_counter_n #(.WIDTH(3), .SATURATE(1'b1)) dut_s (.Clk(Clk), .Reset(rst_s), .bus(if_s.slave));
   gray_counter_n #(.WIDTH(8), .SATURATE(1'b0)) dut_w (.Clk(Clk), .Reset(rst_w), .bus(if_w.slave));

   typedef struct {
      logic       rst, ld, en, dir, clr;
      logic [2:0] lv;
      logic [2:0] g, b;
      logic       ov, un, wr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, ld, en, dir, clr, input logic [2:0] lv,
                      input logic [2:0] g, b, input logic ov, un, wr);
      vec_t v;
      v.rst = rst; v.ld = ld; v.en = en; v.dir = dir; v.clr = clr; v.lv = lv;
      v.g = g; v.b = b; v.ov = ov; v.un = un; v.wr = wr;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive_s(input logic rst, ld, en, dir, clr, input logic [2:0] lv);
      rst_s = rst; if_s.Load = ld; if_s.En = en; if_s.Dir = dir;
      if_s.ClrFlag = clr; if_s.LoadVal = lv;
      tick();
   endtask

   function automatic logic [31:0] pack3(input logic [2:0] g, b, input logic ov, un, wr);
      return {23'd0, g, b, ov, un, wr};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_b;
      logic [7:0] prev_g;

      if_a.En = 0; if_a.Dir = 0; if_a.Load = 0; if_a.LoadVal = '0; if_a.ClrFlag = 0;
      if_s.En = 0; if_s.Dir = 0; if_s.Load = 0; if_s.LoadVal = '0; if_s.ClrFlag = 0;
      if_w.En = 0; if_w.Dir = 0; if_w.Load = 0; if_w.LoadVal = '0; if_w.ClrFlag = 0;

      #1;
      check("powerup_a", pack3(if_a.Output, if_a.Binary, if_a.Overflow, if_a.Underflow, if_a.Wrap), 32'd0);
      check("powerup_w", {if_w.Output, if_w.Binary, if_w.Overflow, if_w.Underflow, if_w.Wrap}, 32'd0);

      // rst ld en dir clr lv    -> gray  bin   ov un wr
      add(1,0,0,0,0,3'b000, 3'b000,3'd0, 0,0,0);
      add(0,0,1,0,0,3'b000, 3'b001,3'd1, 0,0,0);
      add(0,0,1,0,0,3'b000, 3'b011,3'd2, 0,0,0);
      add(0,0,1,0,0,3'b000, 3'b010,3'd3, 0,0,0);
      add(0,0,1,0,0,3'b000, 3'b110,3'd4, 0,0,0);
      add(0,0,1,0,0,3'b000, 3'b111,3'd5, 0,0,0);
      add(0,0,1,0,0,3'b000, 3'b101,3'd6, 0,0,0);
      add(0,0,1,0,0,3'b000, 3'b100,3'd7, 0,0,0);
      add(0,0,1,0,0,3'b000, 3'b000,3'd0, 1,0,1);
      add(0,0,0,0,0,3'b000, 3'b000,3'd0, 1,0,0);
      add(1,0,1,0,0,3'b000, 3'b000,3'd0, 0,0,0);
      add(0,0,1,1,0,3'b000, 3'b100,3'd7, 0,1,1);
      add(0,0,1,1,0,3'b000, 3'b101,3'd6, 0,1,0);
      add(0,1,1,1,0,3'b110, 3'b110,3'd4, 0,1,0);
      add(0,0,1,0,0,3'b000, 3'b111,3'd5, 0,1,0);
      add(0,0,1,0,0,3'b000, 3'b101,3'd6, 0,1,0);
      add(0,0,1,0,0,3'b000, 3'b100,3'd7, 0,1,0);
      add(0,0,1,0,0,3'b000, 3'b000,3'd0, 1,1,1);
      add(0,0,1,1,1,3'b000, 3'b100,3'd7, 0,1,1);
      add(0,0,1,0,0,3'b000, 3'b000,3'd0, 1,1,1);
      add(0,1,0,0,0,3'b100, 3'b100,3'd7, 1,1,0);
      add(0,0,1,0,1,3'b000, 3'b000,3'd0, 1,0,1);
      add(0,0,0,0,1,3'b000, 3'b000,3'd0, 0,0,0);
      add(0,1,0,0,0,3'b111, 3'b111,3'd5, 0,0,0);
      add(1,1,1,0,1,3'b011, 3'b000,3'd0, 0,0,0);
      add(1,0,1,1,0,3'b000, 3'b000,3'd0, 0,0,0);
      add(0,0,1,0,0,3'b000, 3'b001,3'd1, 0,0,0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst_a = vecs[i].rst; if_a.Load = vecs[i].ld; if_a.En = vecs[i].en;
         if_a.Dir = vecs[i].dir; if_a.ClrFlag = vecs[i].clr; if_a.LoadVal = vecs[i].lv;
         tick();
         check($sformatf("wrap_vec%0d", i),
               pack3(if_a.Output, if_a.Binary, if_a.Overflow, if_a.Underflow, if_a.Wrap),
               pack3(vecs[i].g, vecs[i].b, vecs[i].ov, vecs[i].un, vecs[i].wr));
      end
      rst_a = 0; if_a.En = 0; if_a.Load = 0; if_a.ClrFlag = 0;

      // Saturating instance: ends of range hold, flags still set, no wrap pulse.
      drive_s(1,0,0,0,0,3'b000);
      check("sat_reset", pack3(if_s.Output, if_s.Binary, if_s.Overflow, if_s.Underflow, if_s.Wrap),
            pack3(3'b000, 3'd0, 0, 0, 0));
      drive_s(0,1,0,0,0,3'b100);
      check("sat_load", pack3(if_s.Output, if_s.Binary, if_s.Overflow, if_s.Underflow, if_s.Wrap),
            pack3(3'b100, 3'd7, 0, 0, 0));
      for (int k = 0; k < 3; k++) begin
         drive_s(0,0,1,0,0,3'b000);
         check($sformatf("sat_hold_top%0d", k),
               pack3(if_s.Output, if_s.Binary, if_s.Overflow, if_s.Underflow, if_s.Wrap),
               pack3(3'b100, 3'd7, 1, 0, 0));
      end
      drive_s(0,0,1,1,0,3'b000);
      check("sat_down", pack3(if_s.Output, if_s.Binary, if_s.Overflow, if_s.Underflow, if_s.Wrap),
            pack3(3'b101, 3'd6, 1, 0, 0));
      drive_s(0,1,0,0,0,3'b000);
      drive_s(0,0,1,1,0,3'b000);
      check("sat_hold_bottom", pack3(if_s.Output, if_s.Binary, if_s.Overflow, if_s.Underflow, if_s.Wrap),
            pack3(3'b000, 3'd0, 1, 1, 0));
      drive_s(0,0,0,0,1,3'b000);
      check("sat_clear", pack3(if_s.Output, if_s.Binary, if_s.Overflow, if_s.Underflow, if_s.Wrap),
            pack3(3'b000, 3'd0, 0, 0, 0));

      // 8-bit full up sweep then a down wrap; every step must flip one Gray bit.
      rst_w = 1;
      tick();
      rst_w = 0; if_w.En = 1; if_w.Dir = 0;
      exp_b = 8'd0;
      prev_g = if_w.Output;
      for (int k = 0; k < 256; k++) begin
         tick();
         exp_b = exp_b + 8'd1;
         check($sformatf("w8_bin%0d", k), {24'd0, if_w.Binary}, {24'd0, exp_b});
         check($sformatf("w8_gray%0d", k), {24'd0, if_w.Output}, {24'd0, exp_b ^ (exp_b >> 1)});
         check($sformatf("w8_onebit%0d", k), $countones(prev_g ^ if_w.Output), 32'd1);
         check($sformatf("w8_wrap%0d", k), {31'd0, if_w.Wrap}, {31'd0, (exp_b == 8'd0)});
         prev_g = if_w.Output;
      end
      if_w.Dir = 1;
      tick();
      check("w8_down_wrap_bin", {24'd0, if_w.Binary}, 32'd255);
      check("w8_down_wrap_onebit", $countones(prev_g ^ if_w.Output), 32'd1);
      check("w8_down_flags", {30'd0, if_w.Underflow, if_w.Wrap}, 32'd3);
      if_w.En = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/gray_counter_n.md
GRAY_COUNTER_N -- requirements
Module: gray_counter_n

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits; legal range 2..16.
REQ-002 SHALL have parameter SATURATE, default 0: 0 = wrap at the ends of the range, 1 = hold at the ends of the range.
REQ-003 SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port En, input, 1 bit: count enable; one step per cycle while high.
REQ-006 SHALL have port Dir, input, 1 bit: count direction; 0 = up, 1 = down.
REQ-007 SHALL have port Load, input, 1 bit: synchronous load strobe.
REQ-008 SHALL have port LoadVal, input, WIDTH bits: load value, Gray-coded.
REQ-009 SHALL have port ClrFlag, input, 1 bit: clears the sticky Overflow and Underflow flags.
REQ-010 SHALL have port Output, output, WIDTH bits: current count, Gray-coded, registered.
REQ-011 SHALL have port Binary, output, WIDTH bits: current count, binary, registered, always consistent with Output.
REQ-012 SHALL have port Overflow, output, 1 bit: sticky flag; an up-step was attempted from the all-max count.
REQ-013 SHALL have port Underflow, output, 1 bit: sticky flag; a down-step was attempted from count 0.
REQ-014 SHALL have port Wrap, output, 1 bit: one-cycle pulse; the count actually wrapped in the last cycle.

Function
REQ-015 SHALL hold a binary count register B internally and drive Output = B ^ (B >> 1) from a register, so that Output changes in the same cycle as Binary.
REQ-016 SHALL apply per-cycle priority as follows: Reset, then Load, then En.
REQ-017 SHALL, on Load=1, set B = Gray-to-binary(LoadVal), where bit i = XOR of LoadVal bits i..WIDTH-1.
REQ-018 SHALL NOT step the count on a cycle where Load=1, whatever the value of En.
REQ-019 SHALL NOT change Overflow or Underflow because of Load; Wrap SHALL be 0 on a Load cycle.
REQ-020 SHALL, on En=1 with Dir=0 and B < 2^WIDTH-1, set B = B+1; on En=1 with Dir=1 and B > 0, set B = B-1.
REQ-021 SHALL, on En=1 with Dir=0 and B = 2^WIDTH-1:
- set Overflow=1;
- if SATURATE=0, set B=0 and pulse Wrap=1;
- if SATURATE=1, hold B and keep Wrap=0.
REQ-022 SHALL, on En=1 with Dir=1 and B = 0:
- set Underflow=1;
- if SATURATE=0, set B=2^WIDTH-1 and pulse Wrap=1;
- if SATURATE=1, hold B and keep Wrap=0.
REQ-023 SHALL hold B, Output, Binary and both flags on En=0 (and Load=0); Wrap SHALL be 0 on those cycles.
REQ-024 SHALL make Wrap high for exactly the one cycle after the wrapping edge; consecutive wraps SHALL produce consecutive pulses.
REQ-025 SHALL, on ClrFlag=1, clear both sticky flags at the next edge.
REQ-026 SHALL, if ClrFlag=1 coincides with a flag-setting event, leave that flag set (set wins) and clear the other flag.
REQ-027 SHALL change exactly one bit of Output on every En step, including wrap steps in both directions.
REQ-028 SHALL treat a Dir change between cycles as immediate, with no dead cycle.

Reset
REQ-029 SHALL, with Reset=1 at a rising edge, set:
- B=0, Output=0, Binary=0;
- Overflow=0, Underflow=0, Wrap=0.
This holds regardless of En, Load and ClrFlag, including in the middle of a count.
REQ-030 SHALL hold all outputs at their reset values while Reset stays high.
REQ-031 SHALL accept normal operation on the first edge after Reset falls.
REQ-032 SHALL power up with simulation initial values equal to the reset values.

Verification (WIDTH=3 unless noted)
REQ-033 SHALL cover the up sequence: Reset, then En=1, Dir=0 for 9 cycles -> Output = 000,001,011,010,110,111,101,100,000; Overflow=1 from cycle 8 on; Wrap=1 only in cycle 8.
REQ-034 SHALL cover the down wrap: Reset, then En=1, Dir=1 for 1 cycle -> Output=100, Binary=7, Underflow=1, Wrap=1, Overflow=0.
REQ-035 SHALL cover load priority: Load=1, LoadVal=110, En=1 -> Binary=4, Output=110, with no step; the next cycle with En=1, Dir=0 -> Output=111, Binary=5.
REQ-036 SHALL cover saturate mode with SATURATE=1: load 100 (Binary 7), then En=1, Dir=0 for 3 cycles -> Output stays 100, Overflow=1, Wrap always 0.
REQ-037 SHALL cover the ClrFlag collision: Overflow=1 and B=7, then ClrFlag=1 with an up-step -> B=0 and Overflow stays 1; ClrFlag=1 with En=0 on the next cycle -> Overflow=0.
REQ-038 SHALL cover reset mid-count: Reset=1 asserted with B=5 and En=1 -> all outputs 0 at the next edge; with WIDTH=8, a full up sweep SHALL show exactly one Output bit changing per step.
